prio_encoder_pipe: RTL and testbench

PRIO_ENCODER_PIPE -- requirements
Module: prio_encoder_pipe

---
 rtl/prio_enc_pkg.sv | 9 +
 rtl/prio_find.sv | 33 +++
 rtl/prio_encoder_pipe.sv | 78 +++++++
 tb/tb_prio_encoder_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared types for the pipelined priority encoder.
package prio_enc_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } enc_mode_e;

endpackage

// File: rtl/prio_find.sv
// Combinational priority search: winning index plus zero / multi-hot flags.
module prio_find
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  enc_mode_e    mode,
  output logic [W-1:0] idx,
  output logic         zero,
  output logic         multi
);

  // The scan runs toward the preferred end so the last hit is the winner.
  always_comb begin
    idx = '0;
    if (mode == LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

  assign zero  = ~|vec;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/prio_encoder_pipe.sv
// One-stage valid/ready priority encoder with a saturating multi-hot error counter.
module prio_encoder_pipe
  import prio_enc_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     din,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     dout,
  output logic             out_zero,
  output logic             out_multi,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [W-1:0]     find_idx;
  logic             find_zero;
  logic             find_multi;
  logic             accept;

  logic             out_valid_q;
  logic [W-1:0]     dout_q;
  logic             out_zero_q;
  logic             out_multi_q;
  logic [CNT_W-1:0] err_cnt_q;

  prio_find #(
    .N(N),
    .W(W)
  ) u_find (
    .vec  (din),
    .mode (enc_mode_e'(mode)),
    .idx  (find_idx),
    .zero (find_zero),
    .multi(find_multi)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_zero_q  <= 1'b0;
      out_multi_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        dout_q      <= find_idx;
        out_zero_q  <= find_zero;
        out_multi_q <= find_multi;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept && find_multi && (err_cnt_q != CntMax)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_zero  = out_zero_q;
  assign out_multi = out_multi_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Scoreboard bench: a wide-counter N=8 instance and a narrow-counter N=5 instance.
module tb_prio_encoder_pipe;

  typedef struct {
    logic [7:0] dout;
    logic       zero;
    logic       multi;
    logic [7:0] err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid1 = 1'b0, in_ready1, mode1 = 1'b0, out_valid1, out_ready1 = 1'b1;
  logic [7:0] din1 = '0;
  logic [2:0] dout1;
  logic       out_zero1, out_multi1;
  logic [7:0] err_cnt1;

  logic       in_valid2 = 1'b0, in_ready2, mode2 = 1'b0, out_valid2, out_ready2 = 1'b1;
  logic [4:0] din2 = '0;
  logic [2:0] dout2;
  logic       out_zero2, out_multi2;
  logic [1:0] err_cnt2;

  exp_t q1[$];
  exp_t q2[$];
  int   pop_cyc[$];
  int   cycle = 0;
  int   tests = 0;
  int   fails = 0;

  prio_encoder_pipe #(.N(8), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .din(din1),
    .mode(mode1), .out_valid(out_valid1), .out_ready(out_ready1), .dout(dout1),
    .out_zero(out_zero1), .out_multi(out_multi1), .err_cnt(err_cnt1)
  );

  prio_encoder_pipe #(.N(5), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .din(din2),
    .mode(mode2), .out_valid(out_valid2), .out_ready(out_ready2), .dout(dout2),
    .out_zero(out_zero2), .out_multi(out_multi2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors sample just after the falling edge, when the next handshake is settled.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_output", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        pop_cyc.push_back(cycle);
        chk("dut1_dout", 32'(dout1), 32'(e.dout));
        chk("dut1_zero", 32'(out_zero1), 32'(e.zero));
        chk("dut1_multi", 32'(out_multi1), 32'(e.multi));
        chk("dut1_err_cnt", 32'(err_cnt1), 32'(e.err));
      end
    end
  end

  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst_n && out_valid2 && out_ready2) begin
      if (q2.size() == 0) begin
        chk("dut2_unexpected_output", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        chk("dut2_dout", 32'(dout2), 32'(e.dout));
        chk("dut2_zero", 32'(out_zero2), 32'(e.zero));
        chk("dut2_multi", 32'(out_multi2), 32'(e.multi));
        chk("dut2_err_cnt", 32'(err_cnt2), 32'(e.err));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input int which, input logic [7:0] d, input logic m,
                      input logic [7:0] e_dout, input logic e_zero, input logic e_multi,
                      input logic [7:0] e_err);
    exp_t e;
    int   waited;
    e.dout = e_dout; e.zero = e_zero; e.multi = e_multi; e.err = e_err;
    if (which == 1) begin in_valid1 = 1'b1; din1 = d; mode1 = m; end
    else begin in_valid2 = 1'b1; din2 = d[4:0]; mode2 = m; end
    #1;
    waited = 0;
    while (((which == 1) ? in_ready1 : in_ready2) !== 1'b1 && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    if (waited >= 20) begin
      chk("send_timeout", 32'd1, 32'd0);
    end else if (which == 1) begin
      q1.push_back(e);
    end else begin
      q2.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", 32'(in_ready1), 32'd1);
    chk("rst_out_valid", 32'(out_valid1), 32'd0);
    chk("rst_dout", 32'(dout1), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt1), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready1), 32'd1);
    @(negedge clk);

    // Back-to-back one-hot stream at full rate.
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'b0000_0001 << i;
      send(1, v, logic'(i % 2), 8'(i), 1'b0, 1'b0, 8'd0);
    end
    idle();
    wait_drain();
    chk("stream_count", 32'(pop_cyc.size()), 32'd8);
    if (pop_cyc.size() == 8) chk("stream_span", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);

    // Multi-hot, zero and saturating-free error counting.
    send(1, 8'b1001_0100, 1'b0, 8'd2, 1'b0, 1'b1, 8'd1);
    send(1, 8'b1001_0100, 1'b1, 8'd7, 1'b0, 1'b1, 8'd2);
    send(1, 8'b0000_0000, 1'b0, 8'd0, 1'b1, 1'b0, 8'd2);
    send(1, 8'b0000_0000, 1'b1, 8'd0, 1'b1, 1'b0, 8'd2);
    send(1, 8'b1111_1111, 1'b0, 8'd0, 1'b0, 1'b1, 8'd3);
    send(1, 8'b1111_1111, 1'b1, 8'd7, 1'b0, 1'b1, 8'd4);
    send(1, 8'b0110_0000, 1'b1, 8'd6, 1'b0, 1'b1, 8'd5);
    idle();
    wait_drain();

    // Data with in_valid low must be ignored.
    din1 = 8'hFF;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_out_valid", 32'(out_valid1), 32'd0);
    chk("idle_err_cnt", 32'(err_cnt1), 32'd5);
    @(negedge clk);

    // Backpressure: held output frozen, pending vector neither lost nor consumed.
    out_ready1 = 1'b0;
    send(1, 8'b0000_1000, 1'b0, 8'd3, 1'b0, 1'b0, 8'd5);
    in_valid1 = 1'b1; din1 = 8'b0011_0000; mode1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready1), 32'd0);
      chk("stall_out_valid", 32'(out_valid1), 32'd1);
      chk("stall_dout", 32'(dout1), 32'd3);
      chk("stall_err_cnt", 32'(err_cnt1), 32'd5);
      @(negedge clk);
    end
    out_ready1 = 1'b1;
    q1.push_back('{dout: 8'd5, zero: 1'b0, multi: 1'b1, err: 8'd6});
    #1 chk("release_in_ready", 32'(in_ready1), 32'd1);
    @(negedge clk);
    idle();
    wait_drain();

    // Asynchronous reset while an output is held.
    out_ready1 = 1'b0;
    send(1, 8'b0000_0011, 1'b0, 8'd0, 1'b0, 1'b1, 8'd7);
    #1 chk("pre_rst_out_valid", 32'(out_valid1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid1), 32'd0);
    chk("async_rst_err_cnt", 32'(err_cnt1), 32'd0);
    chk("async_rst_out_multi", 32'(out_multi1), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready1), 32'd1);
    q1.delete();
    q2.delete();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("no_replay_out_valid", 32'(out_valid1), 32'd0);
    out_ready1 = 1'b1;
    @(negedge clk);
    send(1, 8'b0100_0000, 1'b1, 8'd6, 1'b0, 1'b0, 8'd0);
    idle();
    wait_drain();

    // Narrow counter saturation on a non-power-of-two width.
    send(2, 8'b000_00011, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1);
    send(2, 8'b000_11000, 1'b1, 8'd4, 1'b0, 1'b1, 8'd2);
    send(2, 8'b000_10101, 1'b0, 8'd0, 1'b0, 1'b1, 8'd3);
    send(2, 8'b000_11111, 1'b1, 8'd4, 1'b0, 1'b1, 8'd3);
    send(2, 8'b000_00110, 1'b1, 8'd2, 1'b0, 1'b1, 8'd3);
    send(2, 8'b000_10000, 1'b0, 8'd4, 1'b0, 1'b0, 8'd3);
    send(2, 8'b000_00000, 1'b1, 8'd0, 1'b1, 1'b0, 8'd3);
    idle();
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
